// File: rtl/taxi_pkg.sv
// Shared trip-meter types and constants.
// TRIP_W is common with the fare calculator; cnt_w sizes prescalers.
package taxi_pkg;

    localparam int TRIP_W              = 16;
    localparam int DEF_CYC_PER_MIN     = 100;
    localparam int DEF_PULSES_PER_UNIT = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } trip_state_t;

    // A prescaler needs at least one bit, even for a divide-by-one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detector.
// Ports: clk, rst (sync, active-high), async_in, rise_pulse (1-cycle).
module pulse_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Driven only from flops, so the consumer sees the edge
    // on the third clock after the input rises.
    assign rise_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/taxi_trip_meter.sv
// Trip front end: counts wheel pulses into distance units and cycles
// into minutes while RUN. Ports: clk, rst, start, stop, wheel_pulse;
// outputs distance, minute (16b, registered), trip_active, trip_done.
module taxi_trip_meter
    import taxi_pkg::*;
#(
    parameter int CYC_PER_MIN     = DEF_CYC_PER_MIN,
    parameter int PULSES_PER_UNIT = DEF_PULSES_PER_UNIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              wheel_pulse,
    output logic [TRIP_W-1:0] distance,
    output logic [TRIP_W-1:0] minute,
    output logic              trip_active,
    output logic              trip_done
);

    localparam int CW = cnt_w(CYC_PER_MIN);
    localparam int PW = cnt_w(PULSES_PER_UNIT);

    localparam logic [CW-1:0]     CYC_LAST = CW'(CYC_PER_MIN - 1);
    localparam logic [PW-1:0]     PUL_LAST = PW'(PULSES_PER_UNIT - 1);
    localparam logic [TRIP_W-1:0] SAT      = '1;

    trip_state_t     state_q;
    trip_state_t     state_d;
    logic [CW-1:0]   cyc_q;
    logic [PW-1:0]   pul_q;
    logic            wheel_rise;
    logic            running;
    logic            enter_run;

    pulse_sync_edge u_wheel (
        .clk        (clk),
        .rst        (rst),
        .async_in   (wheel_pulse),
        .rise_pulse (wheel_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // In RUN only stop is honoured, so stop wins a tie there;
    // elsewhere only start is honoured, so start wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (stop)  state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    assign running   = (state_q == RUN);
    assign enter_run = (state_d == RUN) && (state_q != RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q    <= '0;
            pul_q    <= '0;
            minute   <= '0;
            distance <= '0;
        end else if (enter_run) begin
            cyc_q    <= '0;
            pul_q    <= '0;
            minute   <= '0;
            distance <= '0;
        end else if (running) begin
            if (cyc_q == CYC_LAST) begin
                cyc_q <= '0;
                if (minute != SAT) begin
                    minute <= minute + 16'd1;
                end
            end else begin
                cyc_q <= cyc_q + CW'(1);
            end
            if (wheel_rise) begin
                if (pul_q == PUL_LAST) begin
                    pul_q <= '0;
                    if (distance != SAT) begin
                        distance <= distance + 16'd1;
                    end
                end else begin
                    pul_q <= pul_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trip_active <= 1'b0;
            trip_done   <= 1'b0;
        end else begin
            trip_active <= (state_d == RUN);
            trip_done   <= running && (state_d == DONE);
        end
    end

endmodule
